lut_access_arbiter: RTL and testbench

- Shares one single-port 32-bit coefficient LUT (altera_syncram, SINGLE_PORT, outdata_reg_a = CLOCK0) between NUM_REQ force-pipeline read requesters.
- Uses round-robin arbitration and returns each response only to the requester that issued it.
- Sequences a runtime table reload from the host through a RUN/DRAIN/LOAD state machine.
- Sits between the range-limited force pipelines and each c*_* coefficient table instance.

---
 rtl/lut_access_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_lut_access_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_access_arbiter.sv
// lut_access_arbiter
//   Shares one single-port 32-bit coefficient LUT (registered address and
//   registered output, MEM_LATENCY cycles) between NUM_REQ read requesters
//   using round-robin arbitration. Responses are steered back only to the
//   requester that issued them. A host reload is sequenced through a
//   RUN -> DRAIN -> LOAD -> RUN state machine.
//
//   Optional feature macro: LUT_ARB_ADDR_CHECK_EN
//     Adds the addr_err output. Reads at or above DEPTH are granted but
//     skip the RAM and return zero; writes at or above DEPTH are dropped.
//     Either case sets the sticky addr_err flag.
//
// Ports
//   clock, rst_n            clock, asynchronous active-low reset
//   rd_req / rd_addr        per-requester request and packed address
//   rd_gnt                  one-hot grant, combinational in the request cycle
//   rsp_valid / rsp_data    one-hot response strobe and LUT word
//   load_req / load_ack     host reload handshake (level)
//   wr_valid/wr_addr/wr_data host write, honoured only while load_ack is high
//   mem_*                   LUT address/data/rden/wren/q
//   busy                    any read in flight
//   addr_err                sticky out-of-range flag (macro builds only)
module lut_access_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 3072,
    parameter int MEM_LATENCY = 2
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]            rd_gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [31:0]                   rsp_data,
    input  logic                          load_req,
    output logic                          load_ack,
    input  logic                          wr_valid,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [31:0]                   wr_data,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic [31:0]                   mem_data,
    output logic                          mem_rden,
    output logic                          mem_wren,
    input  logic [31:0]                   mem_q,
    output logic                          busy
`ifdef LUT_ARB_ADDR_CHECK_EN
    ,
    output logic                          addr_err
`endif
);

    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int TAG_DEPTH = 1 + MEM_LATENCY;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_param_check
        $error("lut_access_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0]      rr_ptr;
    logic                  gnt_any;
    logic [IDX_W-1:0]      gnt_idx;
    logic [IDX_W:0]        cand;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic                  arb_en;
    logic                  rd_issue;
    logic                  wr_take;

    logic                  tag_v   [TAG_DEPTH];
    logic [IDX_W-1:0]      tag_idx [TAG_DEPTH];

    // No grant in the cycle load_req is seen, so DRAIN never gains new reads.
    assign arb_en   = (state == RUN) && !load_req;
    assign load_ack = (state == LOAD);

    // Round-robin search starting one past the last winner; the candidate
    // never exceeds 2*NUM_REQ-1, so a single wrap subtraction suffices.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (arb_en && !gnt_any && rd_req[cand[IDX_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        rd_gnt   = '0;
        gnt_addr = '0;
        if (gnt_any) begin
            rd_gnt[gnt_idx] = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                gnt_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

`ifdef LUT_ARB_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    logic rd_oor;
    logic wr_oor;
    logic tag_oor [TAG_DEPTH];
    assign rd_oor   = ({1'b0, gnt_addr} >= DEPTH_W);
    assign wr_oor   = ({1'b0, wr_addr} >= DEPTH_W);
    assign rd_issue = gnt_any && !rd_oor;
    assign wr_take  = (state == LOAD) && wr_valid && !wr_oor;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if ((gnt_any && rd_oor) || ((state == LOAD) && wr_valid && wr_oor)) begin
            addr_err <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
                tag_oor[i] <= 1'b0;
            end
        end else begin
            tag_oor[0] <= rd_oor;
            for (int unsigned i = 1; i < TAG_DEPTH; i++) begin
                tag_oor[i] <= tag_oor[i-1];
            end
        end
    end
`else
    assign rd_issue = gnt_any;
    assign wr_take  = (state == LOAD) && wr_valid;
`endif

    // Tag pipeline tracks which requester owns each read in flight; its
    // last stage lines up with mem_q.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
                tag_v[i]   <= 1'b0;
                tag_idx[i] <= '0;
            end
        end else begin
            tag_v[0]   <= gnt_any;
            tag_idx[0] <= gnt_idx;
            for (int unsigned i = 1; i < TAG_DEPTH; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
            busy = busy | tag_v[i];
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tag_v[TAG_DEPTH-1]) begin
            rsp_valid[tag_idx[TAG_DEPTH-1]] = 1'b1;
            rsp_data = mem_q;
`ifdef LUT_ARB_ADDR_CHECK_EN
            if (tag_oor[TAG_DEPTH-1]) begin
                rsp_data = '0;
            end
`endif
        end
    end

    // Reads and writes come from disjoint states, so the RAM port never
    // sees both strobes at once; mem_address holds between accesses.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
        end else begin
            mem_rden <= rd_issue;
            mem_wren <= wr_take;
            if (rd_issue) begin
                mem_address <= gnt_addr;
            end else if (wr_take) begin
                mem_address <= wr_addr;
                mem_data    <= wr_data;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            if (gnt_any) begin
                rr_ptr <= gnt_idx;
            end
        end
    end

    // A write registered this cycle counts as pending, so LOAD is left only
    // once the RAM port is free of host traffic from the previous cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (load_req) state_nxt = DRAIN;
            DRAIN:   if (!busy) state_nxt = load_req ? LOAD : RUN;
            LOAD:    if (!load_req && !mem_wren) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_lut_access_arbiter.sv
// Self-checking bench for lut_access_arbiter: a RAM stand-in with
// registered address and output, a schedule-based reference model checked
// every cycle, directed scenarios with literal expectations, and a
// randomized phase.
module tb_lut_access_arbiter;

    localparam int N     = 4;
    localparam int AW    = 12;
    localparam int DEPTH = 3072;

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      rd_req = '0;
    logic [N*AW-1:0]   rd_addr = '0;
    logic [N-1:0]      rd_gnt;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_data;
    logic              load_req = 1'b0;
    logic              load_ack;
    logic              wr_valid = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [31:0]       wr_data = '0;
    logic [AW-1:0]     mem_address;
    logic [31:0]       mem_data;
    logic              mem_rden;
    logic              mem_wren;
    logic [31:0]       mem_q;
    logic              busy;
`ifdef LUT_ARB_ADDR_CHECK_EN
    logic              addr_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    lut_access_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .MEM_LATENCY(2)
    ) dut (
        .clock(clock), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .load_req(load_req), .load_ack(load_ack),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
        .busy(busy)
`ifdef LUT_ARB_ADDR_CHECK_EN
        , .addr_err(addr_err)
`endif
    );

    // RAM stand-in: single port, registered address, registered output.
    logic [31:0]   ram     [4096];
    logic [31:0]   ref_mem [4096];
    logic [AW-1:0] ram_areg = '0;
    logic [31:0]   ram_q    = '0;
    assign mem_q = ram_q;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = {16'h5A5A, 16'(i)};
            ref_mem[i] = {16'h5A5A, 16'(i)};
        end
    end

    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) ram_areg <= mem_address;
        ram_q <= ram[ram_areg];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: every grant schedules an issue slot one cycle later
    // and a response slot three cycles later; writes accepted in LOAD
    // schedule a RAM write one cycle later.
    int            cyc = 0;
    int            m_ptr = N - 1;
    int            m_mode = 0;   // 0 = run, 1 = drain, 2 = load
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_data = '0;
    bit            m_err = 1'b0;
    bit            s_rden  [16];
    logic [AW-1:0] s_raddr [16];
    bit            s_wren  [16];
    logic [AW-1:0] s_waddr [16];
    logic [31:0]   s_wdata [16];
    logic [N-1:0]  s_rsp   [16];
    logic [31:0]   s_rdata [16];

    always @(negedge clock) begin
        int s, s1, s3, gi, idx;
        bit e_busy, err_set, oor;
        logic [N-1:0]  e_gnt;
        logic [AW-1:0] a;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                s_rden[i] = 0; s_wren[i] = 0; s_rsp[i] = '0;
            end
            m_ptr = N - 1; m_mode = 0; m_addr = '0; m_data = '0; m_err = 0;
            chk("rst_gnt", rd_gnt, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_load_ack", load_ack, 0);
            chk("rst_mem_rden", mem_rden, 0);
            chk("rst_mem_wren", mem_wren, 0);
            chk("rst_mem_address", mem_address, 0);
            chk("rst_mem_data", mem_data, 0);
            chk("rst_busy", busy, 0);
`ifdef LUT_ARB_ADDR_CHECK_EN
            chk("rst_addr_err", addr_err, 0);
`endif
        end else begin
            s  = cyc % 16;
            s1 = (cyc + 1) % 16;
            s3 = (cyc + 3) % 16;
            if (s_rden[s]) m_addr = s_raddr[s];
            if (s_wren[s]) begin
                m_addr = s_waddr[s];
                m_data = s_wdata[s];
            end
            e_busy = (s_rsp[s] | s_rsp[(s + 1) % 16] | s_rsp[(s + 2) % 16]) != '0;
            gi = -1;
            if (m_mode == 0 && !load_req) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (gi < 0 && rd_req[idx]) gi = idx;
                end
            end
            e_gnt = (gi >= 0) ? (N'(1) << gi) : '0;

            chk("gnt", rd_gnt, e_gnt);
            chk("rsp_valid", rsp_valid, s_rsp[s]);
            if (s_rsp[s] != '0) chk("rsp_data", rsp_data, s_rdata[s]);
            chk("load_ack", load_ack, (m_mode == 2));
            chk("mem_rden", mem_rden, s_rden[s]);
            chk("mem_wren", mem_wren, s_wren[s]);
            chk("mem_address", mem_address, m_addr);
            if (s_wren[s]) chk("mem_data", mem_data, m_data);
            chk("busy", busy, e_busy);
`ifdef LUT_ARB_ADDR_CHECK_EN
            chk("addr_err", addr_err, m_err);
`endif
            err_set = 0;
            if (gi >= 0) begin
                a = rd_addr[gi*AW +: AW];
                m_ptr = gi;
                oor = 0;
`ifdef LUT_ARB_ADDR_CHECK_EN
                oor = (a >= DEPTH);
`endif
                if (oor) err_set = 1;
                else begin
                    s_rden[s1]  = 1;
                    s_raddr[s1] = a;
                end
                s_rsp[s3]   = e_gnt;
                s_rdata[s3] = oor ? 32'h0 : ref_mem[a];
            end
            if (m_mode == 2 && wr_valid) begin
                oor = 0;
`ifdef LUT_ARB_ADDR_CHECK_EN
                oor = (wr_addr >= DEPTH);
`endif
                if (oor) err_set = 1;
                else begin
                    s_wren[s1]  = 1;
                    s_waddr[s1] = wr_addr;
                    s_wdata[s1] = wr_data;
                    ref_mem[wr_addr] = wr_data;
                end
            end
            case (m_mode)
                0: if (load_req) m_mode = 1;
                1: if (!e_busy) m_mode = load_req ? 2 : 0;
                default: if (!load_req && !s_wren[s]) m_mode = 0;
            endcase
            s_rden[s] = 0;
            s_wren[s] = 0;
            s_rsp[s]  = '0;
            m_err = m_err | err_set;
            cyc++;
        end
    end

    // Stimulus: inputs change 1 time unit after the rising edge; directed
    // literal checks sample 2 time units after the rising edge.
    logic [N-1:0] g_last = '0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        rd_addr[i*AW +: AW] = a;
    endtask

    task automatic cycle_hold();
        step();
        rd_req = rd_req & ~g_last;
        #1;
        g_last = rd_gnt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_req = '0; load_req = 0; wr_valid = 0;
        step(); step();
        rst_n = 1'b1;
        g_last = '0;
    endtask

    task automatic wait_rsp(input int r, input string nm, input logic [31:0] expd);
        bit got;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle_hold();
            if (rsp_valid[r]) begin
                got = 1;
                chk(nm, rsp_data, expd);
            end
        end
        chk({nm, "_seen"}, got, 1);
    endtask

    initial begin
        int  pulses;
        bit  got;

        // Reset release and first read.
        do_reset();
        step();
        rd_req = 4'b0001; set_addr(0, 12'd5); #1;
        chk("first_gnt", rd_gnt, 4'b0001);
        step(); rd_req = '0; #1;
        chk("first_rden", mem_rden, 1);
        chk("first_addr", mem_address, 12'd5);
        step(); #1;
        chk("first_rsp_early", rsp_valid, 0);
        step(); #1;
        chk("first_rsp_valid", rsp_valid, 4'b0001);
        chk("first_rsp_data", rsp_data, 32'h5A5A_0005);

        // All four requesting: rotation from requester 0, gapless responses.
        do_reset();
        for (int i = 0; i < N; i++) set_addr(i, AW'(16 + i));
        for (int k = 0; k <= 10; k++) begin
            step();
            if (k == 0) rd_req = 4'b1111;
            if (k == 8) rd_req = 4'b0000;
            #1;
            chk("rr_gnt", rd_gnt, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
            if (k >= 3) chk("rr_rsp", rsp_valid, 4'b0001 << ((k - 3) % 4));
        end
        step(); step(); step();

        // Reload with two reads in flight.
        step(); rd_req = 4'b0011; set_addr(0, 12'd100); set_addr(1, 12'd200); #1;
        chk("ld_gnt0", rd_gnt, 4'b0001);
        step(); rd_req = 4'b0010; #1;
        chk("ld_gnt1", rd_gnt, 4'b0010);
        step(); rd_req = 4'b0100; set_addr(2, 12'd300); load_req = 1; #1;
        chk("ld_blocks_gnt", rd_gnt, 4'b0000);
        pulses = 0; got = 0;
        for (int k = 0; k < 12 && !got; k++) begin
            if (rsp_valid != '0) pulses++;
            if (load_ack) got = 1;
            else begin
                step(); #1;
            end
        end
        chk("ld_ack_rise", got, 1);
        chk("ld_drain_pulses", pulses, 2);
        step(); wr_valid = 1; wr_addr = 12'd7; wr_data = 32'hDEADBEEF; #1;
        step(); wr_valid = 0; load_req = 0; #1;
        chk("ld_wren", mem_wren, 1);
        chk("ld_waddr", mem_address, 12'd7);
        chk("ld_wdata", mem_data, 32'hDEADBEEF);
        step(); rd_req = 4'b1100; set_addr(3, 12'd7); #1;
        g_last = rd_gnt;
        wait_rsp(3, "ld_readback", 32'hDEADBEEF);
        for (int k = 0; k < 6; k++) cycle_hold();

        // Host writes outside LOAD are ignored.
        for (int k = 0; k < 4; k++) begin
            step(); wr_valid = 1; wr_addr = 12'd9; wr_data = 32'h0BAD_F00D; #1;
            chk("run_wr_ignored", mem_wren, 0);
        end
        step(); wr_valid = 0; rd_req = 4'b0001; set_addr(0, 12'd9); #1;
        chk("run_wr_ignored_last", mem_wren, 0);
        g_last = rd_gnt;
        wait_rsp(0, "run_wr_readback", 32'h5A5A_0009);
        for (int k = 0; k < 4; k++) cycle_hold();

        // Reset one cycle after a grant discards the read.
        step(); rd_req = 4'b0010; set_addr(1, 12'd11); #1;
        chk("mid_rst_gnt", rd_gnt, 4'b0010);
        step(); rd_req = '0; rst_n = 0; #1;
        chk("mid_rst_rden", mem_rden, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        step(); rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            step(); #1;
            chk("mid_rst_no_rsp", rsp_valid, 0);
        end
        step(); rd_req = 4'b1111; #1;
        chk("mid_rst_first_winner", rd_gnt, 4'b0001);
        g_last = rd_gnt;
        for (int k = 0; k < 8; k++) cycle_hold();

`ifdef LUT_ARB_ADDR_CHECK_EN
        step(); rd_req = 4'b0001; set_addr(0, 12'd3072); #1;
        chk("oor_gnt", rd_gnt, 4'b0001);
        step(); rd_req = '0; #1;
        chk("oor_no_rden", mem_rden, 0);
        step(); #1;
        chk("oor_err", addr_err, 1);
        step(); #1;
        chk("oor_rsp_valid", rsp_valid, 4'b0001);
        chk("oor_rsp_data", rsp_data, 0);
        g_last = '0;
`endif

        // Randomized traffic with reload episodes and stray host writes.
        for (int c = 0; c < 1500; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (g_last[i]) begin
                    rd_req[i] = 1'($urandom_range(0, 1));
                    set_addr(i, AW'($urandom_range(0, 4095)));
                end else if (!rd_req[i] && $urandom_range(0, 2) == 0) begin
                    rd_req[i] = 1'b1;
                    set_addr(i, AW'($urandom_range(0, 4095)));
                end
            end
            if ($urandom_range(0, 39) == 0) load_req = !load_req;
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, 4095));
            wr_data  = $urandom;
            #1;
            g_last = rd_gnt;
        end
        load_req = 0; wr_valid = 0;
        for (int k = 0; k < 12; k++) cycle_hold();
        rd_req = '0;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
